// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with a one-byte holding register,
// valid/ready hand-off, and single-cycle framing_error / overrun pulses.
module uart_byte_receiver #(
   parameter int CLOCKS_PER_BIT = 868
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       uart_receive,
   output logic [7:0] data,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int CW = $clog2(CLOCKS_PER_BIT);
   // start bit is re-checked at its midpoint; data/stop bits one full bit later
   localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t          state, state_next;
   logic [1:0]      sync_q;
   logic            rx;
   logic [CW-1:0]   count;
   logic [2:0]      bit_idx;
   logic [7:0]      shift_q;
   logic            sample;
   logic            stop_good;
   logic            stop_bad;
   logic            load;
   logic            drop;

   // two-flop synchronizer; resets to the idle-high line level
   always_ff @(posedge clock or posedge reset) begin
      if (reset) sync_q <= 2'b11;
      else       sync_q <= {sync_q[0], uart_receive};
   end

   assign rx = sync_q[1];

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // FSM next-state: glitchy starts fall back to IDLE, bad stops park in BREAK
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!rx) state_next = START;
         START:   if (count == HALF_LAST) state_next = rx ? IDLE : DATA;
         DATA:    if (count == BIT_LAST && bit_idx == 3'd7) state_next = STOP;
         STOP:    if (count == BIT_LAST) state_next = rx ? IDLE : BREAK;
         BREAK:   if (rx) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: sample strobe and stop-bit outcome decode
   always_comb begin
      sample = 1'b0;
      case (state)
         START:      sample = (count == HALF_LAST);
         DATA, STOP: sample = (count == BIT_LAST);
         default:    sample = 1'b0;
      endcase
      stop_good = (state == STOP) && sample && rx;
      stop_bad  = (state == STOP) && sample && !rx;
      // a slot frees up in the same cycle the consumer drains it
      load      = stop_good && (!data_valid || data_ready);
      drop      = stop_good && !load;
   end

   // bit timing counter, bit index and LSB-first shift register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count   <= '0;
         bit_idx <= 3'd0;
         shift_q <= 8'h00;
      end else begin
         if (sample || state_next != state || state == IDLE || state == BREAK)
            count <= '0;
         else
            count <= count + CW'(1);
         if (state == START && sample)
            bit_idx <= 3'd0;
         if (state == DATA && sample) begin
            shift_q <= {rx, shift_q[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
      end
   end

   // holding register, valid/ready hand-off and status pulses
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data          <= 8'h00;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         framing_error <= stop_bad;
         overrun       <= drop;
         if (load) begin
            data       <= shift_q;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb_uart_byte_receiver: directed plus randomized frames against a
// consumer-side model (ordered list of bytes that must reach the consumer).
module tb_uart_byte_receiver;

   localparam int CPB = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       uart_receive = 1'b1;
   logic       data_ready = 1'b0;
   logic [7:0] data;
   logic       data_valid;
   logic       framing_error;
   logic       overrun;

   int checks = 0;
   int failures = 0;

   // observation counters, written only by the monitor
   int         hs_n = 0, dv_cyc = 0, fe_cyc = 0, ov_cyc = 0;
   int         both_cyc = 0, stab_err = 0;
   logic [7:0] acc_mem [0:255];
   logic       prev_dv = 1'b0, prev_hs = 1'b0;
   logic [7:0] prev_data = 8'h00;

   // model: bytes the consumer must see, in order
   logic [7:0] exp_q[$];
   int         acc_rd = 0;

   uart_byte_receiver #(.CLOCKS_PER_BIT(CPB)) dut (
      .clock         (clock),
      .reset         (reset),
      .uart_receive  (uart_receive),
      .data          (data),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .framing_error (framing_error),
      .overrun       (overrun)
   );

   always #5 clock = ~clock;

   // monitor: sample outputs mid-cycle, log handshakes and pulse cycles
   always @(negedge clock) begin
      if (data_valid) dv_cyc <= dv_cyc + 1;
      if (framing_error) fe_cyc <= fe_cyc + 1;
      if (overrun) ov_cyc <= ov_cyc + 1;
      if (framing_error && overrun) both_cyc <= both_cyc + 1;
      if (data_valid && data_ready) begin
         acc_mem[hs_n[7:0]] <= data;
         hs_n <= hs_n + 1;
      end
      if (prev_dv && !prev_hs && data_valid && data !== prev_data)
         stab_err <= stab_err + 1;
      prev_dv   <= data_valid;
      prev_hs   <= data_valid && data_ready;
      prev_data <= data;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // one 8N1 frame; ready_at >= 0 pulses data_ready in that bit-clock slot only
   task automatic drive_frame(input logic [7:0] b, input logic stop_v, input int ready_at);
      logic [9:0] bits;
      bits = {stop_v, b, 1'b0};
      for (int c = 0; c < 10 * CPB; c++) begin
         uart_receive = bits[c / CPB];
         if (ready_at >= 0) data_ready = (c == ready_at);
         tick(1);
      end
   endtask

   task automatic expect_accepts(input string tag);
      while (exp_q.size() > 0) begin
         check(tag, acc_mem[acc_rd], exp_q.pop_front());
         acc_rd++;
      end
      check({tag, "_count"}, hs_n, acc_rd);
   endtask

   initial begin
      logic [9:0] bits;
      logic [7:0] b, first;
      logic       bad;
      int         dv0, fe0, ov0, nbad, k;

      // reset takes effect before any clock edge
      #1 reset = 1'b1;
      #1;
      check("rst_data", data, 8'h00);
      check("rst_valid", data_valid, 1'b0);
      check("rst_fe", framing_error, 1'b0);
      check("rst_ov", overrun, 1'b0);
      tick(3);
      reset = 1'b0;
      tick(20);

      // single frame with consumer always ready
      data_ready = 1'b1;
      dv0 = dv_cyc; fe0 = fe_cyc; ov0 = ov_cyc;
      drive_frame(8'hA5, 1'b1, -1);
      tick(30);
      exp_q.push_back(8'hA5);
      expect_accepts("a5_byte");
      check("a5_dv_cycles", dv_cyc - dv0, 1);
      check("a5_fe", fe_cyc - fe0, 0);
      check("a5_ov", ov_cyc - ov0, 0);

      // back-to-back frames, consumer stalled: second byte overruns
      data_ready = 1'b0;
      ov0 = ov_cyc;
      drive_frame(8'h3C, 1'b1, -1);
      drive_frame(8'hC3, 1'b1, -1);
      tick(20);
      check("ovr_data", data, 8'h3C);
      check("ovr_valid", data_valid, 1'b1);
      check("ovr_pulse", ov_cyc - ov0, 1);
      data_ready = 1'b1;
      tick(3);
      data_ready = 1'b0;
      exp_q.push_back(8'h3C);
      expect_accepts("ovr_byte");
      check("ovr_drained", data_valid, 1'b0);

      // stop bit low, then a long break, then a clean frame
      data_ready = 1'b1;
      dv0 = dv_cyc; fe0 = fe_cyc;
      drive_frame(8'h55, 1'b0, -1);
      tick(40 * CPB);
      check("brk_fe", fe_cyc - fe0, 1);
      check("brk_dv", dv_cyc - dv0, 0);
      uart_receive = 1'b1;
      tick(2 * CPB);
      drive_frame(8'h12, 1'b1, -1);
      tick(30);
      exp_q.push_back(8'h12);
      expect_accepts("brk_next");

      // short low glitch is rejected silently
      dv0 = dv_cyc; fe0 = fe_cyc; ov0 = ov_cyc;
      uart_receive = 1'b0;
      tick(5);
      uart_receive = 1'b1;
      tick(3 * CPB);
      check("gl_dv", dv_cyc - dv0, 0);
      check("gl_fe", fe_cyc - fe0, 0);
      check("gl_ov", ov_cyc - ov0, 0);
      drive_frame(8'hFF, 1'b1, -1);
      tick(30);
      exp_q.push_back(8'hFF);
      expect_accepts("gl_next");

      // reset in the middle of data bit 4, released while the line is high
      bits = {1'b1, 8'h81, 1'b0};
      dv0 = dv_cyc;
      for (int c = 0; c < 10 * CPB; c++) begin
         uart_receive = bits[c / CPB];
         if (c == 5 * CPB + 8) begin
            #2 reset = 1'b1;
            #1;
            check("mid_rst_data", data, 8'h00);
            check("mid_rst_valid", data_valid, 1'b0);
            check("mid_rst_fe", framing_error, 1'b0);
            check("mid_rst_ov", overrun, 1'b0);
            dv0 = dv_cyc;
         end
         if (c == 8 * CPB + 4) reset = 1'b0;
         tick(1);
      end
      tick(3 * CPB);
      check("mid_rst_no_dv", dv_cyc - dv0, 0);
      drive_frame(8'h5A, 1'b1, -1);
      tick(30);
      exp_q.push_back(8'h5A);
      expect_accepts("mid_rst_next");

      // drain in the same cycle as the next stop sample: reload, no overrun
      data_ready = 1'b0;
      ov0 = ov_cyc;
      drive_frame(8'h01, 1'b1, -1);
      tick(10);
      check("same_held", data, 8'h01);
      // stop sample edge = 2 sync + 1 detect + CPB/2 + 9*CPB clocks after the fall
      drive_frame(8'h02, 1'b1, 3 + CPB / 2 + 9 * CPB - 1);
      tick(10);
      check("same_data", data, 8'h02);
      check("same_valid", data_valid, 1'b1);
      check("same_ov", ov_cyc - ov0, 0);
      data_ready = 1'b1;
      tick(2);
      data_ready = 1'b0;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      expect_accepts("same_bytes");

      // random frames, random gaps, occasional bad stop bit, consumer ready
      data_ready = 1'b1;
      fe0 = fe_cyc; ov0 = ov_cyc; nbad = 0;
      for (int i = 0; i < 12; i++) begin
         b   = 8'($urandom_range(0, 255));
         bad = ($urandom_range(0, 4) == 0);
         drive_frame(b, !bad, -1);
         if (bad) nbad++;
         else     exp_q.push_back(b);
         uart_receive = 1'b1;
         tick(bad ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 40)));
      end
      tick(30);
      expect_accepts("rnd_byte");
      check("rnd_fe", fe_cyc - fe0, nbad);
      check("rnd_ov", ov_cyc - ov0, 0);

      // random burst into a stalled consumer: only the first byte survives
      data_ready = 1'b0;
      ov0 = ov_cyc;
      k = int'($urandom_range(2, 4));
      first = 8'h00;
      for (int i = 0; i < k; i++) begin
         b = 8'($urandom_range(0, 255));
         if (i == 0) first = b;
         drive_frame(b, 1'b1, -1);
      end
      tick(20);
      check("burst_ov", ov_cyc - ov0, k - 1);
      check("burst_data", data, first);
      check("burst_valid", data_valid, 1'b1);
      data_ready = 1'b1;
      tick(2);
      data_ready = 1'b0;
      exp_q.push_back(first);
      expect_accepts("burst_byte");

      tick(10);
      check("fe_ov_overlap", both_cyc, 0);
      check("data_stable", stab_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
